// File: rtl/stage2_execute.sv
// stage2_execute: execute stage of the 2-stage RV32IM pipeline.
// Resolves branches/jumps, runs the ALU and an iterative restoring divider,
// and registers the writeback and data-memory request for the next stage.
module stage2_execute #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] id_pc_r,
  input  logic [XLEN-1:0] id_next_pc_r,
  input  logic [4:0]      id_rd_index_r,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            id_a_signed_r,
  input  logic            id_b_signed_r,
  input  logic [3:0]      id_alu_op_r,
  input  logic [XLEN-1:0] id_imm_r,
  input  logic            id_op_imm_r,
  input  logic            id_mem_rd_r,
  input  logic            id_mem_wr_r,
  input  logic            id_mem_signed_r,
  input  logic [1:0]      id_mem_size_r,
  input  logic [2:0]      id_branch_r,
  input  logic            id_reg_jump_r,
  output logic            branch_taken_w,
  output logic [XLEN-1:0] jump_addr_w,
  output logic            ex_stall_w,
  output logic [4:0]      ex_rd_index_r,
  output logic [XLEN-1:0] ex_rd_data_r,
  output logic            ex_rd_we_r,
  output logic [XLEN-1:0] ex_mem_addr_r,
  output logic [XLEN-1:0] ex_mem_wdata_r,
  output logic            ex_mem_rd_r,
  output logic            ex_mem_wr_r,
  output logic            ex_mem_signed_r,
  output logic [1:0]      ex_mem_size_r
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_MUL   = 4'd8;
  localparam logic [3:0] ALU_MULH  = 4'd9;
  localparam logic [3:0] ALU_DIV   = 4'd10;
  localparam logic [3:0] ALU_REM   = 4'd11;
  localparam logic [3:0] ALU_PASSB = 4'd12;
  localparam logic [3:0] ALU_PCADD = 4'd13;
  localparam int         CNT_W     = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_e;
  divState_e divState_q, divState_d;

  logic [XLEN-1:0]  opA, opB;
  logic             aNeg, bNeg;
  logic             squash, valid, isDivOp, divStart, divStall;
  logic [63:0]      mulA, mulB, mulFull;
  logic [XLEN-1:0]  shrRes, aluResult, jumpTarget;
  logic             branchCond;

  logic             branchTaken_q, branchTaken_d;
  logic [XLEN-1:0]  jumpAddr_q, jumpAddr_d;
  logic [4:0]       rdIndex_q, rdIndex_d;
  logic [XLEN-1:0]  rdData_q, rdData_d;
  logic             rdWe_q, rdWe_d;
  logic [XLEN-1:0]  memAddr_q, memAddr_d, memWdata_q, memWdata_d;
  logic             memRd_q, memRd_d, memWr_q, memWr_d, memSigned_q, memSigned_d;
  logic [1:0]       memSize_q, memSize_d;

  logic [XLEN-1:0]  divRem_q, divRem_d, divQuot_q, divQuot_d, divDivisor_q, divDivisor_d;
  logic [CNT_W-1:0] divCount_q, divCount_d;
  logic             divNegQ_q, divNegQ_d, divNegR_q, divNegR_d;
  logic             divByZero_q, divByZero_d, divIsRem_q, divIsRem_d;
  logic [4:0]       divRd_q, divRd_d;
  logic [XLEN:0]    divShifted, divTrial;
  logic [XLEN-1:0]  divResult;

  // The cycle after a redirect, whatever sits in ID is wrong-path.
  assign squash   = branchTaken_q;
  assign valid    = ~squash & (divState_q == DIV_IDLE);
  assign isDivOp  = (id_alu_op_r == ALU_DIV) | (id_alu_op_r == ALU_REM);
  assign divStart = valid & isDivOp;

  assign opA  = rs1_data_i;
  assign opB  = id_op_imm_r ? id_imm_r : rs2_data_i;
  assign aNeg = id_a_signed_r & opA[XLEN-1];
  assign bNeg = id_b_signed_r & opB[XLEN-1];

  assign mulA    = {{(64-XLEN){aNeg}}, opA};
  assign mulB    = {{(64-XLEN){bNeg}}, opB};
  assign mulFull = mulA * mulB;
  assign shrRes  = (opA >> opB[4:0]) | ({XLEN{aNeg}} & ~({XLEN{1'b1}} >> opB[4:0]));

  assign jumpTarget = (id_reg_jump_r ? (opA + id_imm_r) : (id_pc_r + id_imm_r)) & ~32'h3;

  assign divShifted = {divRem_q, divQuot_q[XLEN-1]};
  assign divTrial   = divShifted - {1'b0, divDivisor_q};

  // ALU result for every non-divide op.
  always_comb begin
    aluResult = '0;
    case (id_alu_op_r)
      ALU_ADD:   aluResult = opA + opB;
      ALU_SUB:   aluResult = opA - opB;
      ALU_AND:   aluResult = opA & opB;
      ALU_OR:    aluResult = opA | opB;
      ALU_XOR:   aluResult = opA ^ opB;
      ALU_SLT:   aluResult = {31'b0, ($signed({aNeg, opA}) < $signed({bNeg, opB}))};
      ALU_SHL:   aluResult = opA << opB[4:0];
      ALU_SHR:   aluResult = shrRes;
      ALU_MUL:   aluResult = mulFull[31:0];
      ALU_MULH:  aluResult = mulFull[63:32];
      ALU_PASSB: aluResult = opB;
      ALU_PCADD: aluResult = id_pc_r + id_imm_r;
      default:   aluResult = '0;
    endcase
  end

  // Branch condition; code 1 is an unconditional jump.
  always_comb begin
    branchCond = 1'b0;
    case (id_branch_r)
      3'd1:    branchCond = 1'b1;
      3'd2:    branchCond = (opA == opB);
      3'd3:    branchCond = (opA != opB);
      3'd4:    branchCond = ($signed(opA) <  $signed(opB));
      3'd5:    branchCond = ($signed(opA) >= $signed(opB));
      3'd6:    branchCond = (opA <  opB);
      3'd7:    branchCond = (opA >= opB);
      default: branchCond = 1'b0;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) divState_q <= DIV_IDLE;
    else         divState_q <= divState_d;
  end

  // Divider next state: DONE always lasts one cycle so the held DIV cannot restart.
  always_comb begin
    divState_d = divState_q;
    case (divState_q)
      DIV_IDLE: if (divStart) divState_d = DIV_BUSY;
      DIV_BUSY: if (divCount_q == CNT_W'(1)) divState_d = DIV_DONE;
      DIV_DONE: divState_d = DIV_IDLE;
      default:  divState_d = DIV_IDLE;
    endcase
  end

  // Divider outputs: the front end holds only while iterating.
  always_comb begin
    divStall = (divState_q == DIV_BUSY);
  end

  // Divider datapath: latch magnitudes on start, one restoring step per BUSY cycle.
  always_comb begin
    divRem_d     = divRem_q;
    divQuot_d    = divQuot_q;
    divDivisor_d = divDivisor_q;
    divCount_d   = divCount_q;
    divNegQ_d    = divNegQ_q;
    divNegR_d    = divNegR_q;
    divByZero_d  = divByZero_q;
    divIsRem_d   = divIsRem_q;
    divRd_d      = divRd_q;
    if (divState_q == DIV_IDLE && divStart) begin
      divRem_d     = '0;
      divQuot_d    = aNeg ? -opA : opA;
      divDivisor_d = bNeg ? -opB : opB;
      divCount_d   = CNT_W'(DIV_CYCLES);
      divNegQ_d    = aNeg ^ bNeg;
      divNegR_d    = aNeg;
      divByZero_d  = (opB == '0);
      divIsRem_d   = (id_alu_op_r == ALU_REM);
      divRd_d      = id_rd_index_r;
    end else if (divState_q == DIV_BUSY) begin
      divCount_d = divCount_q - CNT_W'(1);
      if (!divTrial[XLEN]) begin
        divRem_d  = divTrial[XLEN-1:0];
        divQuot_d = {divQuot_q[XLEN-2:0], 1'b1};
      end else begin
        divRem_d  = divShifted[XLEN-1:0];
        divQuot_d = {divQuot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the unsigned core; a zero divisor leaves the dividend as remainder.
  always_comb begin
    if (divIsRem_q)       divResult = divNegR_q ? -divRem_q : divRem_q;
    else if (divByZero_q) divResult = '1;
    else                  divResult = divNegQ_q ? -divQuot_q : divQuot_q;
  end

  // Divider datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      divRem_q     <= '0;
      divQuot_q    <= '0;
      divDivisor_q <= '0;
      divCount_q   <= '0;
      divNegQ_q    <= 1'b0;
      divNegR_q    <= 1'b0;
      divByZero_q  <= 1'b0;
      divIsRem_q   <= 1'b0;
      divRd_q      <= '0;
    end else begin
      divRem_q     <= divRem_d;
      divQuot_q    <= divQuot_d;
      divDivisor_q <= divDivisor_d;
      divCount_q   <= divCount_d;
      divNegQ_q    <= divNegQ_d;
      divNegR_q    <= divNegR_d;
      divByZero_q  <= divByZero_d;
      divIsRem_q   <= divIsRem_d;
      divRd_q      <= divRd_d;
    end
  end

  // Next writeback/memory/redirect values; only a valid ID instruction may act.
  always_comb begin
    branchTaken_d = valid & (id_branch_r != 3'd0) & branchCond;
    jumpAddr_d    = jumpTarget;
    memRd_d       = valid & id_mem_rd_r;
    memWr_d       = valid & id_mem_wr_r;
    memAddr_d     = opA + id_imm_r;
    memWdata_d    = rs2_data_i;
    memSigned_d   = id_mem_signed_r;
    memSize_d     = id_mem_size_r;
    if (divState_q == DIV_DONE) begin
      rdIndex_d = divRd_q;
      rdData_d  = divResult;
      rdWe_d    = (divRd_q != 5'd0);
    end else begin
      rdIndex_d = id_rd_index_r;
      rdData_d  = (id_branch_r == 3'd1) ? id_next_pc_r : aluResult;
      rdWe_d    = valid & (id_rd_index_r != 5'd0) & (id_branch_r <= 3'd1) & ~id_mem_wr_r & ~isDivOp;
    end
  end

  // Output pipeline registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branchTaken_q <= 1'b0;
      jumpAddr_q    <= '0;
      rdIndex_q     <= '0;
      rdData_q      <= '0;
      rdWe_q        <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memRd_q       <= 1'b0;
      memWr_q       <= 1'b0;
      memSigned_q   <= 1'b0;
      memSize_q     <= '0;
    end else begin
      branchTaken_q <= branchTaken_d;
      jumpAddr_q    <= jumpAddr_d;
      rdIndex_q     <= rdIndex_d;
      rdData_q      <= rdData_d;
      rdWe_q        <= rdWe_d;
      memAddr_q     <= memAddr_d;
      memWdata_q    <= memWdata_d;
      memRd_q       <= memRd_d;
      memWr_q       <= memWr_d;
      memSigned_q   <= memSigned_d;
      memSize_q     <= memSize_d;
    end
  end

  assign branch_taken_w  = branchTaken_q;
  assign jump_addr_w     = jumpAddr_q;
  assign ex_stall_w      = divStall;
  assign ex_rd_index_r   = rdIndex_q;
  assign ex_rd_data_r    = rdData_q;
  assign ex_rd_we_r      = rdWe_q;
  assign ex_mem_addr_r   = memAddr_q;
  assign ex_mem_wdata_r  = memWdata_q;
  assign ex_mem_rd_r     = memRd_q;
  assign ex_mem_wr_r     = memWr_q;
  assign ex_mem_signed_r = memSigned_q;
  assign ex_mem_size_r   = memSize_q;

endmodule

// File: tb/tb_stage2_execute.sv
// tb_stage2_execute: randomized bench for the execute stage against an
// arithmetic reference model of instruction results, redirects and divides.
module tb_stage2_execute;

  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rd;
    logic        aS, bS;
    logic [3:0]  op;
    logic        opImm, memRd, memWr, memSigned;
    logic [1:0]  memSize;
    logic [2:0]  br;
    logic        regJump;
  } instr_t;

  typedef struct {
    logic        taken;
    logic [31:0] jaddr;
    logic        we;
    logic [31:0] data;
    logic        memRd, memWr;
    logic [31:0] addr;
  } expect_t;

  logic        clk, reset;
  logic [31:0] idPc, idNextPc, rs1Data, rs2Data, idImm;
  logic [4:0]  idRdIndex;
  logic        idASigned, idBSigned, idOpImm, idMemRd, idMemWr, idMemSigned, idRegJump;
  logic [3:0]  idAluOp;
  logic [1:0]  idMemSize;
  logic [2:0]  idBranch;
  logic        branchTaken, exStall, exRdWe, exMemRd, exMemWr, exMemSigned;
  logic [31:0] jumpAddr, exRdData, exMemAddr, exMemWdata;
  logic [4:0]  exRdIndex;
  logic [1:0]  exMemSize;

  int checkCount = 0;
  int errorCount = 0;
  bit expSquash  = 0;

  stage2_execute dut (
    .clk_i(clk), .reset_i(reset),
    .id_pc_r(idPc), .id_next_pc_r(idNextPc), .id_rd_index_r(idRdIndex),
    .rs1_data_i(rs1Data), .rs2_data_i(rs2Data),
    .id_a_signed_r(idASigned), .id_b_signed_r(idBSigned),
    .id_alu_op_r(idAluOp), .id_imm_r(idImm), .id_op_imm_r(idOpImm),
    .id_mem_rd_r(idMemRd), .id_mem_wr_r(idMemWr),
    .id_mem_signed_r(idMemSigned), .id_mem_size_r(idMemSize),
    .id_branch_r(idBranch), .id_reg_jump_r(idRegJump),
    .branch_taken_w(branchTaken), .jump_addr_w(jumpAddr), .ex_stall_w(exStall),
    .ex_rd_index_r(exRdIndex), .ex_rd_data_r(exRdData), .ex_rd_we_r(exRdWe),
    .ex_mem_addr_r(exMemAddr), .ex_mem_wdata_r(exMemWdata),
    .ex_mem_rd_r(exMemRd), .ex_mem_wr_r(exMemWr),
    .ex_mem_signed_r(exMemSigned), .ex_mem_size_r(exMemSize)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic instr_t nopInstr();
    instr_t n;
    n = '{default: '0};
    return n;
  endfunction

  task automatic applyStimulus(input instr_t ins);
    idPc        = ins.pc;
    idNextPc    = ins.pc + 32'd4;
    idRdIndex   = ins.rd;
    rs1Data     = ins.a;
    rs2Data     = ins.b;
    idASigned   = ins.aS;
    idBSigned   = ins.bS;
    idAluOp     = ins.op;
    idImm       = ins.imm;
    idOpImm     = ins.opImm;
    idMemRd     = ins.memRd;
    idMemWr     = ins.memWr;
    idMemSigned = ins.memSigned;
    idMemSize   = ins.memSize;
    idBranch    = ins.br;
    idRegJump   = ins.regJump;
  endtask

  // Reference ALU: true operand values as 64-bit integers, results truncated.
  function automatic logic [31:0] modelAlu(instr_t ins);
    logic [31:0] a = ins.a;
    logic [31:0] b = ins.opImm ? ins.imm : ins.b;
    longint va = ins.aS ? longint'($signed(a)) : longint'({32'b0, a});
    longint vb = ins.bS ? longint'($signed(b)) : longint'({32'b0, b});
    longint prod = va * vb;
    longint shr  = va >>> b[4:0];
    case (ins.op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (va < vb) ? 32'd1 : 32'd0;
      4'd6:  return a << b[4:0];
      4'd7:  return ins.aS ? shr[31:0] : (a >> b[4:0]);
      4'd8:  return prod[31:0];
      4'd9:  return prod[63:32];
      4'd12: return b;
      4'd13: return ins.pc + ins.imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelDiv(logic [31:0] a, logic [31:0] b, logic aS, logic bS, logic isRem);
    longint va = aS ? longint'($signed(a)) : longint'({32'b0, a});
    longint vb = bS ? longint'($signed(b)) : longint'({32'b0, b});
    longint q, r;
    if (vb == 0) return isRem ? a : 32'hFFFFFFFF;
    q = va / vb;
    r = va % vb;
    return isRem ? r[31:0] : q[31:0];
  endfunction

  function automatic expect_t modelExecute(instr_t ins, bit squashed);
    expect_t e;
    logic    cond;
    logic [31:0] tgt;
    case (ins.br)
      3'd1:    cond = 1'b1;
      3'd2:    cond = (ins.a == ins.b);
      3'd3:    cond = (ins.a != ins.b);
      3'd4:    cond = ($signed(ins.a) <  $signed(ins.b));
      3'd5:    cond = ($signed(ins.a) >= $signed(ins.b));
      3'd6:    cond = (ins.a <  ins.b);
      3'd7:    cond = (ins.a >= ins.b);
      default: cond = 1'b0;
    endcase
    tgt     = ins.regJump ? (ins.a + ins.imm) : (ins.pc + ins.imm);
    e.taken = !squashed && ins.br != 3'd0 && cond;
    e.jaddr = tgt & ~32'h3;
    e.we    = !squashed && ins.rd != 5'd0 && ins.br <= 3'd1 && !ins.memWr;
    e.data  = (ins.br == 3'd1) ? ins.pc + 32'd4 : modelAlu(ins);
    e.memRd = !squashed && ins.memRd;
    e.memWr = !squashed && ins.memWr;
    e.addr  = ins.a + ins.imm;
    return e;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " taken"},  branchTaken, 0);
    checkOutput({tag, " jaddr"},  jumpAddr,    0);
    checkOutput({tag, " stall"},  exStall,     0);
    checkOutput({tag, " rdidx"},  exRdIndex,   0);
    checkOutput({tag, " rddata"}, exRdData,    0);
    checkOutput({tag, " we"},     exRdWe,      0);
    checkOutput({tag, " addr"},   exMemAddr,   0);
    checkOutput({tag, " wdata"},  exMemWdata,  0);
    checkOutput({tag, " memrd"},  exMemRd,     0);
    checkOutput({tag, " memwr"},  exMemWr,     0);
    checkOutput({tag, " msign"},  exMemSigned, 0);
    checkOutput({tag, " msize"},  exMemSize,   0);
  endtask

  // Drive one instruction for one cycle and compare the registered result.
  task automatic execInstr(input string tag, input instr_t ins);
    expect_t e;
    applyStimulus(ins);
    e = modelExecute(ins, expSquash);
    @(posedge clk); #1;
    checkOutput({tag, " taken"}, branchTaken, e.taken);
    if (e.taken) checkOutput({tag, " jaddr"}, jumpAddr, e.jaddr);
    checkOutput({tag, " we"}, exRdWe, e.we);
    if (e.we) begin
      checkOutput({tag, " rddata"}, exRdData, e.data);
      checkOutput({tag, " rdidx"}, exRdIndex, ins.rd);
    end
    checkOutput({tag, " memrd"}, exMemRd, e.memRd);
    checkOutput({tag, " memwr"}, exMemWr, e.memWr);
    if (e.memRd || e.memWr) checkOutput({tag, " addr"}, exMemAddr, e.addr);
    if (e.memWr) checkOutput({tag, " wdata"}, exMemWdata, ins.b);
    if (e.memRd) begin
      checkOutput({tag, " msign"}, exMemSigned, ins.memSigned);
      checkOutput({tag, " msize"}, exMemSize, ins.memSize);
    end
    checkOutput({tag, " stall"}, exStall, 0);
    expSquash = e.taken;
  endtask

  // Hold a DIV/REM in ID through the whole stall and check timing and result.
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic aS, input logic bS, input logic isRem, input logic [4:0] rd);
    instr_t ins;
    int     stallCycles = 0;
    bit     sawWrite = 0;
    bit     done = 0;
    ins    = nopInstr();
    ins.a  = a; ins.b = b; ins.aS = aS; ins.bS = bS; ins.rd = rd;
    ins.op = isRem ? 4'd11 : 4'd10;
    applyStimulus(ins);
    checkOutput({tag, " stallS"}, exStall, 0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (exStall) begin
        stallCycles++;
        if (exRdWe || exMemRd || exMemWr || branchTaken) sawWrite = 1;
      end else begin
        done = 1;
      end
    end
    checkOutput({tag, " stallcnt"}, stallCycles, 32);
    checkOutput({tag, " busywr"}, sawWrite, 0);
    checkOutput({tag, " donewe"}, exRdWe, 0);
    @(posedge clk); #1;
    checkOutput({tag, " we"}, exRdWe, rd != 5'd0);
    if (rd != 5'd0) begin
      checkOutput({tag, " result"}, exRdData, modelDiv(a, b, aS, bS, isRem));
      checkOutput({tag, " rdidx"}, exRdIndex, rd);
    end
    checkOutput({tag, " norestart"}, exStall, 0);
    applyStimulus(nopInstr());
    expSquash = 0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t randInstr();
    instr_t ins;
    int     kind = $urandom_range(0, 9);
    int     op;
    ins         = nopInstr();
    ins.pc      = $urandom & ~32'h3;
    ins.a       = pickOperand();
    ins.b       = ($urandom_range(0, 3) == 0) ? ins.a : pickOperand();
    ins.imm     = $urandom;
    ins.rd      = 5'($urandom_range(0, 31));
    ins.aS      = 1'($urandom_range(0, 1));
    ins.bS      = 1'($urandom_range(0, 1));
    if (kind <= 4) begin
      op = $urandom_range(0, 13);
      if (op >= 10) op += 2;
      ins.op    = 4'(op);
      ins.opImm = 1'($urandom_range(0, 1));
    end else if (kind <= 6) begin
      ins.opImm     = 1'b1;
      ins.imm       = $urandom_range(0, 255);
      ins.memRd     = (kind == 5);
      ins.memWr     = (kind == 6);
      ins.memSigned = 1'($urandom_range(0, 1));
      ins.memSize   = 2'($urandom_range(0, 2));
    end else if (kind <= 8) begin
      ins.br  = 3'($urandom_range(2, 7));
      ins.imm = $urandom & 32'h1FFE;
    end else begin
      ins.br      = 3'd1;
      ins.regJump = 1'($urandom_range(0, 1));
    end
    return ins;
  endfunction

  initial begin
    instr_t ins;
    bit     stray;
    reset = 1'b1;
    applyStimulus(nopInstr());
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    ins = nopInstr();
    ins.a = 32'd5; ins.imm = 32'hFFFFFFFD; ins.opImm = 1'b1; ins.rd = 5'd7;
    execInstr("add", ins);
    checkOutput("add const", exRdData, 32'd2);

    ins = nopInstr();
    ins.a = 32'h10; ins.b = 32'h10; ins.pc = 32'h100; ins.imm = 32'd8; ins.br = 3'd2;
    execInstr("beq", ins);
    checkOutput("beq target", jumpAddr, 32'h108);
    ins = nopInstr();
    ins.a = 32'd1; ins.b = 32'd2; ins.rd = 5'd9;
    execInstr("squashed add", ins);
    execInstr("after squash", ins);

    ins = nopInstr();
    ins.a = 32'h203; ins.imm = 32'd2; ins.rd = 5'd1; ins.pc = 32'h40;
    ins.br = 3'd1; ins.regJump = 1'b1; ins.opImm = 1'b1;
    execInstr("jalr", ins);
    checkOutput("jalr target", jumpAddr, 32'h204);
    checkOutput("jalr link", exRdData, 32'h44);
    execInstr("post jalr", nopInstr());
    execInstr("nop", nopInstr());

    runDiv("div", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 1'b0, 5'd3);
    runDiv("rem", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, 1'b1, 5'd3);
    runDiv("divu0", 32'd1234, 32'd0, 1'b0, 1'b0, 1'b0, 5'd4);
    runDiv("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd5);
    runDiv("ovfrem", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 5'd5);
    runDiv("rem0", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, 1'b1, 5'd6);
    runDiv("b2b", 32'd1000, 32'd33, 1'b0, 1'b0, 1'b0, 5'd8);
    for (int i = 0; i < 6; i++)
      runDiv("rdiv", pickOperand(), ($urandom_range(0, 3) == 0) ? 32'd0 : pickOperand(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    ins = nopInstr();
    ins.br = 3'd1; ins.pc = 32'h80; ins.imm = 32'h20;
    execInstr("jal", ins);
    ins = nopInstr();
    ins.op = 4'd10; ins.a = 32'd50; ins.b = 32'd5; ins.rd = 5'd2;
    applyStimulus(ins);
    @(posedge clk); #1;
    checkOutput("squashed div stall", exStall, 0);
    checkOutput("squashed div we", exRdWe, 0);
    applyStimulus(nopInstr());
    @(posedge clk); #1;
    checkOutput("squashed div idle", exStall, 0);
    expSquash = 0;

    ins = nopInstr();
    ins.op = 4'd10; ins.a = 32'd999; ins.b = 32'd3; ins.rd = 5'd10;
    applyStimulus(ins);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy10 stall", exStall, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkAllZero("midreset");
    reset = 1'b0;
    applyStimulus(nopInstr());
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exRdWe || exStall) stray = 1;
    end
    checkOutput("midreset quiet", stray, 0);
    expSquash = 0;
    runDiv("postreset", 32'd999, 32'd3, 1'b0, 1'b0, 1'b0, 5'd10);

    for (int i = 0; i < 300; i++) execInstr("rnd", randInstr());

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
